// File: rtl/mod_scoreboard.sv
// Result checker for the MOD datapath: compares measured vs reference remainders,
// counts checks/errors, captures the first mismatch and flags done/pass.
module mod_scoreboard #(
    parameter int unsigned DATAWIDTH  = 32,
    parameter int unsigned CNTWIDTH   = 16,
    parameter int unsigned NUM_CHECKS = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic [DATAWIDTH-1:0] meas,
    // "ref" is a reserved word, hence ref_val.
    input  logic [DATAWIDTH-1:0] ref_val,
    input  logic                 valid,
    output logic                 err,
    output logic                 err_sticky,
    output logic [CNTWIDTH-1:0]  check_cnt,
    output logic [CNTWIDTH-1:0]  err_cnt,
    output logic [DATAWIDTH-1:0] first_err_meas,
    output logic [DATAWIDTH-1:0] first_err_ref,
    output logic [CNTWIDTH-1:0]  first_err_idx,
    output logic                 done,
    output logic                 pass
);

    typedef enum logic [0:0] {StRun, StDone} state_e;

    localparam logic [CNTWIDTH-1:0] LastIdx = CNTWIDTH'(NUM_CHECKS - 1);
    localparam logic [CNTWIDTH-1:0] CntMax  = '1;
    localparam logic [CNTWIDTH-1:0] CntOne  = CNTWIDTH'(1);

    state_e state;
    logic   mismatch;

    assign mismatch = (meas != ref_val);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state          <= StRun;
            err            <= 1'b0;
            err_sticky     <= 1'b0;
            check_cnt      <= '0;
            err_cnt        <= '0;
            first_err_meas <= '0;
            first_err_ref  <= '0;
            first_err_idx  <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                StRun: begin
                    // Only look at meas/ref under valid so X on idle data stays out of err.
                    if (valid) begin
                        err <= mismatch;
                        if (check_cnt != CntMax) begin
                            check_cnt <= check_cnt + CntOne;
                        end
                        if (mismatch) begin
                            if (err_cnt != CntMax) begin
                                err_cnt <= err_cnt + CntOne;
                            end
                            if (!err_sticky) begin
                                err_sticky     <= 1'b1;
                                first_err_meas <= meas;
                                first_err_ref  <= ref_val;
                                first_err_idx  <= check_cnt;
                            end
                        end
                        if (check_cnt == LastIdx) begin
                            state <= StDone;
                            done  <= 1'b1;
                            pass  <= (err_cnt == '0) && !mismatch;
                        end
                    end
                end
                StDone: begin
                    state <= StDone;
                end
                default: begin
                    state <= StRun;
                end
            endcase
        end
    end

endmodule
